apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
- Shares one APB master port between two requesters (e.g. two AHB-side bridge front-ends, or a bridge and a DMA/config engine).
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases, including wait states via pready.
- Returns read data and slave error to the granted requester.
- Adds an ACCESS-phase timeout so a hung slave cannot lock the bus.

Parameters:
- ADDR_W, 32, address width of requests and paddr
- DATA_W, 32, width of wdata/rdata/pwdata/prdata
- TIMEOUT, 16, maximum ACCESS cycles before forced error completion (>=2)

Ports:
- hclk  in  1  system clock, rising edge
- hresetn  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a command pending
- req0_write  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  target address
- req0_wdata  in  DATA_W  write data
- req0_ready  out  1  command accepted this cycle (combinational)
- req0_done  out  1  one-cycle completion pulse
- req0_rdata  out  DATA_W  read data, valid with req0_done
- req0_err  out  1  error flag, valid with req0_done
- req1_*  same set as req0_*, for requester 1
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB slave ready
- pslverr  in  1  APB slave error

Behaviour:
- Clocking/reset: one clock, hclk. hresetn is asynchronous, active-low.
  - Reset values: psel, penable, pwrite, paddr, pwdata, reqN_done, reqN_rdata, reqN_err all 0; FSM=IDLE; last_grant=1.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- Arbitration: round-robin on the requesters' valid signals.
  - The requester not equal to last_grant has priority.
  - If only one requester is valid, it wins.
  - last_grant updates to the winner on each accept.
  - After reset, req0 wins a tie.
- Accept point: an accept occurs in IDLE, or in ACCESS on the completing cycle, when any reqN_valid=1.
  - The winner sees reqN_ready=1 in that same cycle; the other sees 0.
  - At that edge, the winner's write, addr and wdata are captured into pwrite/paddr/pwdata; psel becomes 1 and penable 0, and the FSM goes to SETUP.
  - Requesters must hold valid and the command stable until ready; ready is never asserted with valid low.
- SETUP: lasts exactly 1 cycle, then ACCESS with penable=1. paddr, pwrite and pwdata stay stable.
- ACCESS: a cycle is completing when pready=1, or when the wait counter reaches TIMEOUT-1.
  - The wait counter clears on entry to ACCESS and increments each non-completing ACCESS cycle.
  - On a completing cycle, the granted requester's reqN_done is set to 1 for exactly the next cycle.
  - On pready completion: reqN_rdata = prdata for reads, 0 for writes; reqN_err = pslverr.
  - On timeout completion: reqN_rdata = 0, reqN_err = 1. psel/penable are dropped even though pready never came.
  - After completion: if a new accept occurs the FSM goes to SETUP (psel stays 1, penable goes 0: back-to-back). Otherwise it goes to IDLE with psel=penable=0.
- Data hold: reqN_rdata and reqN_err hold their value until that requester's next done.
- Latency: accept to done is 3 cycles with zero wait states, plus 1 per wait state. Maximum is 2+TIMEOUT.
- Simultaneous valid on both requesters: serviced alternately, with no idle cycle between transfers.
- Reset mid-transfer: outputs clear asynchronously, the in-flight transfer is dropped, and no done pulse is issued.
- A new valid arriving during SETUP or non-completing ACCESS waits; it is not accepted until the completing cycle.

Test Plan:
- Single write, zero wait: req0 write addr=0x10 wdata=0xDEADBEEF, pready=1.
  - -> req0_ready in cycle 0; SETUP in cycle 1 (psel=1, penable=0, paddr=0x10); ACCESS in cycle 2; req0_done in cycle 3 with err=0, rdata=0.
- Read with 2 wait states: req1 read addr=0x20; pready low for 2 ACCESS cycles then high with prdata=0x12345678.
  - -> penable high for 3 cycles; req1_done 5 cycles after accept with rdata=0x12345678.
- Contention: both requesters hold valid for 4 transfers, pready=1.
  - -> grants are req0, req1, req0, req1; psel never drops; a new SETUP follows each ACCESS directly.
- Slave error: write with pslverr=1 and pready=1.
  - -> reqN_done with err=1.
- Timeout: TIMEOUT=16, pready held 0.
  - -> exactly 16 ACCESS cycles; then done with err=1, rdata=0; psel drops to 0.
- Reset mid-ACCESS: assert hresetn=0 during a wait state.
  - -> psel/penable go to 0 immediately; no done pulse; after release, req0 wins a tie.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin front end for a single APB master port.
// Sequences SETUP/ACCESS, returns read data/error, and forces an error completion on slave timeout.
module apb_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                err0_q, err0_d, err1_q, err1_d;

  logic                pready_done_s;
  logic                timeout_done_s;
  logic                completing_s;
  logic                window_s;
  logic                grant0_s;
  logic                grant1_s;
  logic                accept_s;
  logic [DATA_W-1:0]   res_rdata_s;
  logic                res_err_s;

  // pready wins over a timeout that lands on the same cycle
  assign pready_done_s  = (state_q == ST_ACCESS) && pready;
  assign timeout_done_s = (state_q == ST_ACCESS) && !pready && (wait_cnt_q == CNT_LAST);
  assign completing_s   = pready_done_s || timeout_done_s;
  assign window_s       = (state_q == ST_IDLE) || completing_s;
  assign grant0_s       = window_s && req0_valid && (!req1_valid || last_grant_q);
  assign grant1_s       = window_s && req1_valid && (!req0_valid || !last_grant_q);
  assign accept_s       = grant0_s || grant1_s;
  assign res_rdata_s    = (pready_done_s && !pwrite_q) ? prdata : {DATA_W{1'b0}};
  assign res_err_s      = pready_done_s ? pslverr : 1'b1;

  // Next-state, APB phase sequencing, completion capture and command capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;

    case (state_q)
      ST_IDLE: begin
        state_d = accept_s ? ST_SETUP : ST_IDLE;
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = {CNT_W{1'b0}};
      end
      ST_ACCESS: begin
        if (completing_s) begin
          state_d   = accept_s ? ST_SETUP : ST_IDLE;
          psel_d    = accept_s;
          penable_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (completing_s) begin
      if (owner_q) begin
        done1_d  = 1'b1;
        rdata1_d = res_rdata_s;
        err1_d   = res_err_s;
      end else begin
        done0_d  = 1'b1;
        rdata0_d = res_rdata_s;
        err0_d   = res_err_s;
      end
    end else begin
      done0_d = 1'b0;
      done1_d = 1'b0;
    end

    // Accepted command is latched straight onto the APB outputs for SETUP
    if (accept_s) begin
      psel_d       = 1'b1;
      penable_d    = 1'b0;
      pwrite_d     = grant1_s ? req1_write : req0_write;
      paddr_d      = grant1_s ? req1_addr  : req0_addr;
      pwdata_d     = grant1_s ? req1_wdata : req0_wdata;
      last_grant_d = grant1_s;
      owner_d      = grant1_s;
    end else begin
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
    end
  end

  // State and output registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      wait_cnt_q   <= {CNT_W{1'b0}};
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= {ADDR_W{1'b0}};
      pwdata_q     <= {DATA_W{1'b0}};
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= {DATA_W{1'b0}};
      rdata1_q     <= {DATA_W{1'b0}};
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wait_cnt_q   <= wait_cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_apb_rr_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic              req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;

  int n_checks = 0;
  int n_fail   = 0;

  apb_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  task automatic test_reset;
    hresetn = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    @(negedge hclk);
    n_checks++;
    if ({psel, penable, pwrite, req0_done, req1_done, req0_err, req1_err, req0_ready, req1_ready} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {psel, penable, pwrite, req0_done, req1_done, req0_err, req1_err, req0_ready, req1_ready});
    end
    n_checks++;
    if ({paddr, pwdata, req0_rdata, req1_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: paddr=%h pwdata=%h r0=%h r1=%h expected all 0", paddr, pwdata, req0_rdata, req1_rdata);
    end
    hresetn = 1'b1;
    @(negedge hclk);
    n_checks++;
    if (psel !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_psel: got %b expected 0", psel);
    end
  endtask

  task automatic test_single_write;
    @(negedge hclk);
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h10; req0_wdata = 32'hDEADBEEF;
    pready = 1'b1; pslverr = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_ready: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
    end
    @(negedge hclk);
    n_checks++;
    if ({psel, penable, pwrite, req0_ready} !== 4'b1010 || paddr !== 32'h10 || pwdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_setup: psel=%b pen=%b pwr=%b rdy=%b paddr=%h pwdata=%h expected 1,0,1,0,10,deadbeef",
               psel, penable, pwrite, req0_ready, paddr, pwdata);
    end
    req0_valid = 1'b0;
    @(negedge hclk);
    n_checks++;
    if ({psel, penable, req0_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL wr_access: psel=%b pen=%b done=%b expected 1,1,0", psel, penable, req0_done);
    end
    @(negedge hclk);
    n_checks++;
    if ({req0_done, req0_err, psel, req1_done} !== 4'b1000 || req0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_done: done=%b err=%b psel=%b d1=%b rdata=%h expected 1,0,0,0,0",
               req0_done, req0_err, psel, req1_done, req0_rdata);
    end
    @(negedge hclk);
    n_checks++;
    if (req0_done !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done_pulse: got %b expected 0", req0_done);
    end
  endtask

  task automatic test_read_wait;
    @(negedge hclk);
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h20; pready = 1'b0; prdata = 32'h0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_ready: got r0=%b r1=%b expected r0=0 r1=1", req0_ready, req1_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge hclk);
      n_checks++;
      if (penable !== (k >= 2 && k <= 4) || req1_done !== (k == 5)) begin
        n_fail++;
        $display("FAIL rd_wait cycle %0d: pen=%b done=%b expected pen=%b done=%b",
                 k, penable, req1_done, (k >= 2 && k <= 4), (k == 5));
      end
      if (k == 1) begin
        n_checks++;
        if (paddr !== 32'h20 || pwrite !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_setup: paddr=%h pwrite=%b expected 20,0", paddr, pwrite);
        end
        req1_valid = 1'b0;
      end
      if (k == 4) begin
        pready = 1'b1; prdata = 32'h12345678;
      end
      if (k == 5) begin
        n_checks++;
        if (req1_rdata !== 32'h12345678 || req1_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_data: rdata=%h err=%b expected 12345678,0", req1_rdata, req1_err);
        end
      end
    end
  endtask

  task automatic test_contention;
    logic e_r0, e_r1, e_ps, e_pe, e_d0, e_d1;
    @(negedge hclk);
    pready = 1'b1; prdata = 32'hCAFE0001;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h100; req0_wdata = 32'hA0A0A0A0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h200;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge hclk);
      #1;
      e_r0 = (k == 0 || k == 4);
      e_r1 = (k == 2 || k == 6);
      e_ps = (k >= 1 && k <= 8);
      e_pe = (k == 2 || k == 4 || k == 6 || k == 8);
      e_d0 = (k == 3 || k == 7);
      e_d1 = (k == 5 || k == 9);
      n_checks++;
      if ({req0_ready, req1_ready, psel, penable, req0_done, req1_done} !== {e_r0, e_r1, e_ps, e_pe, e_d0, e_d1}) begin
        n_fail++;
        $display("FAIL contend cycle %0d: rdy0,rdy1,psel,pen,d0,d1 got %b expected %b", k,
                 {req0_ready, req1_ready, psel, penable, req0_done, req1_done},
                 {e_r0, e_r1, e_ps, e_pe, e_d0, e_d1});
      end
      if (k == 1 || k == 3 || k == 5 || k == 7) begin
        n_checks++;
        if (paddr !== ((k == 1 || k == 5) ? 32'h100 : 32'h200)) begin
          n_fail++;
          $display("FAIL contend_addr cycle %0d: got %h", k, paddr);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (req1_rdata !== 32'hCAFE0001 || req0_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL contend_data: r1=%h r0=%h expected cafe0001,0", req1_rdata, req0_rdata);
        end
        req0_valid = 1'b0;
      end
      if (k == 7) req1_valid = 1'b0;
    end
  endtask

  task automatic test_slave_error;
    @(negedge hclk);
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h30; req1_wdata = 32'h55;
    pready = 1'b1; pslverr = 1'b1;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ready: got %b expected 1", req1_ready);
    end
    @(negedge hclk);
    req1_valid = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    n_checks++;
    if ({req1_done, req1_err, req0_err} !== 3'b110 || req1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL slverr: done=%b err=%b err0=%b rdata=%h expected 1,1,0,0",
               req1_done, req1_err, req0_err, req1_rdata);
    end
    pslverr = 1'b0;
  endtask

  task automatic test_timeout;
    @(negedge hclk);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h40; pready = 1'b0; prdata = 32'hFFFF0000;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_ready: got %b expected 1", req0_ready);
    end
    for (int k = 1; k <= 19; k++) begin
      @(negedge hclk);
      if (k == 1) req0_valid = 1'b0;
      n_checks++;
      if (penable !== (k >= 2 && k <= 17) || psel !== (k <= 17) || req0_done !== (k == 18)) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: psel=%b pen=%b done=%b expected %b,%b,%b", k, psel, penable,
                 req0_done, (k <= 17), (k >= 2 && k <= 17), (k == 18));
      end
      if (k == 18) begin
        n_checks++;
        if (req0_err !== 1'b1 || req0_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL timeout_resp: err=%b rdata=%h expected 1,0", req0_err, req0_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge hclk);
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h50; pready = 1'b0;
    @(negedge hclk);
    req1_valid = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    n_checks++;
    if ({psel, penable} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre: psel=%b pen=%b expected 1,1", psel, penable);
    end
    hresetn = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, req1_err} !== 3'b000 || paddr !== 32'h0 || req1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: psel=%b pen=%b err1=%b paddr=%h r1=%h expected all 0",
               psel, penable, req1_err, paddr, req1_rdata);
    end
    @(negedge hclk);
    n_checks++;
    if ({req0_done, req1_done, psel} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_nodone: d0=%b d1=%b psel=%b expected 0,0,0", req0_done, req1_done, psel);
    end
    hresetn = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h60; req0_wdata = 32'h77;
    req1_valid = 1'b1; pready = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_tie: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
    end
    @(negedge hclk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    n_checks++;
    if ({req0_done, req1_done, req0_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_after: d0=%b d1=%b err0=%b expected 1,0,0", req0_done, req1_done, req0_err);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_wait;
    test_contention;
    test_slave_error;
    test_timeout;
    test_reset_mid_access;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
